matmul_ctrl: RTL and testbench
==============================

MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter N, default 2, matrix dimension (NxN, N >= 2).
REQ-002 SHALL have parameter DW, default 8, unsigned operand width.
REQ-003 SHALL have parameter AW, default 6, memory address width.
REQ-004 SHALL have parameter ACCW, default 16, accumulator and C-element width.
REQ-005 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  request one multiply; sampled only in IDLE.
REQ-008 SHALL have port busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports rd_en_a / rd_addr_a  out  1 / AW  matrix A read request.
REQ-011 SHALL have port rd_data_a  in  DW  A data, valid one cycle after rd_en_a.
REQ-012 SHALL have ports rd_en_b / rd_addr_b / rd_data_b  out / out / in  1 / AW / DW  B read; same timing as A.
REQ-013 SHALL have ports wr_en_c / wr_addr_c / wr_data_c  out  1 / AW / ACCW  matrix C write strobe, address and value.
REQ-014 SHALL have port sat  out  1  sticky overflow flag for the current run.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, MAC, WRITE and DONE.
REQ-016 SHALL move IDLE->READ on the clock edge that samples start=1; i, j, k and the accumulator clear to 0, and sat clears to 0.
REQ-017 SHALL assert rd_en_a/rd_en_b in READ, with rd_addr_a=i*N+k and rd_addr_b=k*N+j (row-major); both are low in every other state.
REQ-018 SHALL add rd_data_a*rd_data_b (unsigned, full 2*DW product) to the accumulator in MAC.
REQ-019 SHALL go MAC->READ with k+1 when k<N-1, and MAC->WRITE otherwise.
REQ-020 SHALL hold wr_en_c=1 for exactly one cycle in WRITE, with wr_addr_c=i*N+j and wr_data_c=accumulator; the accumulator and k then clear.
REQ-021 SHALL go WRITE->READ with j+1 when j<N-1, or with j=0 and i+1 when i<N-1, and WRITE->DONE when i=j=N-1.
REQ-022 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-023 SHALL spend exactly N*N*(2N+1)+1 cycles out of IDLE per run (21 for N=2).
REQ-024 SHALL ignore start while busy, with no queueing; start held high through DONE begins a new run on the IDLE cycle that follows.
REQ-025 SHALL wrap accumulator overflow modulo 2^ACCW when the saturation feature is absent; sat then stays 0.
REQ-026 SHALL leave the outputs of the final C element unchanged until the next WRITE; wr_en_c alone qualifies them.

Reset
REQ-027 SHALL, while rst=0, force state=IDLE; busy, done, rd_en_a, rd_en_b, wr_en_c and sat=0; all addresses, wr_data_c, the accumulator and i/j/k=0.
REQ-028 SHALL abort a run when reset asserts mid-run, with no further C write; a later start begins a full run.

Configuration
REQ-029 SHALL provide macro MATMUL_SAT_EN; when defined, an accumulate exceeding 2^ACCW-1 clamps to 2^ACCW-1 and sets sat, which holds until the next start or reset.
REQ-030 SHALL, when MATMUL_SAT_EN is undefined, follow REQ-025 and tie sat to 0.

Structure
REQ-031 SHALL place the state encodings (IDLE=0 ... DONE=4) and the default N/DW/AW/ACCW values in the shared package/include matmul_pkg.
REQ-032 SHALL use one sub-module, mac_unit, holding the multiply, the accumulate, the clear, and the MATMUL_SAT_EN clamp and overflow detect.

Verification
REQ-033 SHALL cover: A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> C writes 19@0, 22@1, 43@2, 50@3 in that order, done on the 21st busy cycle.
REQ-034 SHALL cover: A=B=all 255, MATMUL_SAT_EN undefined -> every C=64514 (130050 mod 65536), sat=0.
REQ-035 SHALL cover: A=B=all 255, MATMUL_SAT_EN defined -> every C=65535, sat=1 after the first WRITE and until the next start.
REQ-036 SHALL cover: start pulsed again at busy cycle 5 -> no effect, exactly 4 writes, single done.
REQ-037 SHALL cover: rst=0 during the second element's MAC -> outputs reach reset values immediately, no further writes; a new start gives the correct full result.
REQ-038 SHALL cover: start held high continuously -> back-to-back runs, with one IDLE cycle between done and the next READ.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul_ctrl slice: default sizes, FSM state encodings
// and the row-major index helper.
package matmul_pkg;

  localparam int N_DEF    = 2;
  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 6;
  localparam int ACCW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int unsigned rm_index(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned dim);
    return row * dim + col;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath for matmul_ctrl. Define MATMUL_SAT_EN to clamp on
// overflow and raise the sticky sat flag; otherwise the accumulator wraps.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mac_en,
  input  logic            acc_clr,
  input  logic            sat_clr,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] acc,
  output logic [ACCW-1:0] acc_next,
  output logic            sat
);

  logic [2*DW-1:0] prod;

  assign prod = a * b;

`ifdef MATMUL_SAT_EN
  localparam int SW = ((ACCW > 2*DW) ? ACCW : 2*DW) + 1;

  logic [SW-1:0] sum;
  logic          ovf;

  assign sum      = SW'(acc) + SW'(prod);
  assign ovf      = |sum[SW-1:ACCW];
  assign acc_next = ovf ? '1 : sum[ACCW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat <= 1'b0;
    end else if (sat_clr) begin
      sat <= 1'b0;
    end else if (mac_en && ovf) begin
      sat <= 1'b1;
    end
  end
`else
  logic unused_sat_clr;

  assign acc_next       = acc + ACCW'(prod);
  assign sat            = 1'b0;
  assign unused_sat_clr = sat_clr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/matmul_ctrl.sv
// NxN matrix multiply sequencer: reads A/B row-major, accumulates in mac_unit and
// writes each C element once. Optional MATMUL_SAT_EN selects saturating accumulate.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en_a,
  output logic [AW-1:0]   rd_addr_a,
  input  logic [DW-1:0]   rd_data_a,
  output logic            rd_en_b,
  output logic [AW-1:0]   rd_addr_b,
  input  logic [DW-1:0]   rd_data_b,
  output logic            wr_en_c,
  output logic [AW-1:0]   wr_addr_c,
  output logic [ACCW-1:0] wr_data_c,
  output logic            sat
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   i;
  logic [CW-1:0]   j;
  logic [CW-1:0]   k;
  logic            i_last;
  logic            j_last;
  logic            k_last;
  logic            run_go;
  logic            mac_en;
  logic            acc_clr;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] acc_next;

  assign i_last  = (i == LAST);
  assign j_last  = (j == LAST);
  assign k_last  = (k == LAST);
  assign run_go  = (state == IDLE) && start;
  assign mac_en  = (state == MAC);
  assign acc_clr = run_go || (state == WRITE);

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign rd_en_a = (state == READ);
  assign rd_en_b = (state == READ);
  assign wr_en_c = (state == WRITE);

  assign rd_addr_a = AW'(rm_index(32'(i), 32'(k), N));
  assign rd_addr_b = AW'(rm_index(32'(k), 32'(j), N));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = MAC;
      MAC:     state_nxt = k_last ? WRITE : READ;
      WRITE:   state_nxt = (i_last && j_last) ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // i/j are left on the last element after DONE; only a new start clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        MAC: begin
          if (!k_last) k <= k + CW'(1);
        end
        WRITE: begin
          k <= '0;
          if (!j_last) begin
            j <= j + CW'(1);
          end else if (!i_last) begin
            j <= '0;
            i <= i + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // C outputs are captured from the final MAC's sum so they are valid during WRITE
  // and then held until the next element.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr_c <= '0;
      wr_data_c <= '0;
    end else if (mac_en && k_last) begin
      wr_addr_c <= AW'(rm_index(32'(i), 32'(j), N));
      wr_data_c <= acc_next;
    end
  end

  mac_unit #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .mac_en   (mac_en),
    .acc_clr  (acc_clr),
    .sat_clr  (run_go),
    .a        (rd_data_a),
    .b        (rd_data_b),
    .acc      (acc),
    .acc_next (acc_next),
    .sat      (sat)
  );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed self-checking bench for matmul_ctrl (N=2, DW=8, AW=6, ACCW=16).
module tb_matmul_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        rd_en_a;
  logic [5:0]  rd_addr_a;
  logic [7:0]  rd_data_a;
  logic        rd_en_b;
  logic [5:0]  rd_addr_b;
  logic [7:0]  rd_data_b;
  logic        wr_en_c;
  logic [5:0]  wr_addr_c;
  logic [15:0] wr_data_c;
  logic        sat;

  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];

  int checks;
  int errors;
  int busy_cnt;
  int done_cnt;
  int done_at;
  logic [5:0]  wq_addr [$];
  logic [15:0] wq_data [$];
  logic        wq_sat  [$];

`ifdef MATMUL_SAT_EN
  localparam logic [15:0] EXP_BIG = 16'd65535;
  localparam logic        EXP_SAT = 1'b1;
`else
  localparam logic [15:0] EXP_BIG = 16'd64514;
  localparam logic        EXP_SAT = 1'b0;
`endif

  matmul_ctrl #(
    .N    (2),
    .DW   (8),
    .AW   (6),
    .ACCW (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en_c   (wr_en_c),
    .wr_addr_c (wr_addr_c),
    .wr_data_c (wr_data_c),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data one cycle after the enable.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_at = busy_cnt;
    end
    if (wr_en_c) begin
      wq_addr.push_back(wr_addr_c);
      wq_data.push_back(wr_data_c);
      wq_sat.push_back(sat);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    mem_a[0] = a0; mem_a[1] = a1; mem_a[2] = a2; mem_a[3] = a3;
    mem_b[0] = b0; mem_b[1] = b1; mem_b[2] = b2; mem_b[3] = b3;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run_check(input string tag, input int pulse_at,
                           input logic [15:0] e0, e1, e2, e3, input logic exp_sat);
    int base_b;
    int base_d;
    int base_w;
    logic [15:0] exp_c [4];
    exp_c[0] = e0; exp_c[1] = e1; exp_c[2] = e2; exp_c[3] = e3;
    base_b = busy_cnt;
    base_d = done_cnt;
    base_w = wq_addr.size();
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_sat_cleared"}, 32'(sat), 32'd0);
    if (pulse_at > 0) begin
      repeat (pulse_at - 1) step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_done(tag);
    step();
    chk({tag, "_idle_after_done"}, 32'(busy), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt - base_d), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_at - base_b), 32'd21);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt - base_b), 32'd21);
    chk({tag, "_write_count"}, 32'(wq_addr.size() - base_w), 32'd4);
    if (wq_addr.size() - base_w == 4) begin
      for (int e = 0; e < 4; e++) begin
        chk($sformatf("%s_addr%0d", tag, e), 32'(wq_addr[base_w + e]), 32'(e));
        chk($sformatf("%s_data%0d", tag, e), 32'(wq_data[base_w + e]), 32'(exp_c[e]));
        chk($sformatf("%s_sat%0d", tag, e), 32'(wq_sat[base_w + e]), 32'(exp_sat));
      end
    end
    chk({tag, "_sat_end"}, 32'(sat), 32'(exp_sat));
  endtask

  initial begin
    int base_w;
    int base_d;
    checks   = 0;
    errors   = 0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    rst      = 1'b0;
    start    = 1'b0;
    for (int m = 0; m < 64; m++) begin
      mem_a[m] = 8'd0;
      mem_b[m] = 8'd0;
    end

    // Reset values
    repeat (2) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en_a", 32'(rd_en_a), 32'd0);
    chk("rst_rd_en_b", 32'(rd_en_b), 32'd0);
    chk("rst_wr_en_c", 32'(wr_en_c), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_rd_addr_a", 32'(rd_addr_a), 32'd0);
    chk("rst_rd_addr_b", 32'(rd_addr_b), 32'd0);
    chk("rst_wr_addr_c", 32'(wr_addr_c), 32'd0);
    chk("rst_wr_data_c", 32'(wr_data_c), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_no_start", 32'(busy), 32'd0);

    // Basic product: [[1,2],[3,4]] x [[5,6],[7,8]]
    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    run_check("basic", 0, 16'd19, 16'd22, 16'd43, 16'd50, 1'b0);
    chk("basic_hold_addr", 32'(wr_addr_c), 32'd3);
    chk("basic_hold_data", 32'(wr_data_c), 32'd50);

    // All-255 operands: wrap or clamp depending on build
    load(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    run_check("big", 0, EXP_BIG, EXP_BIG, EXP_BIG, EXP_BIG, EXP_SAT);
    step();
    chk("big_sat_hold", 32'(sat), 32'(EXP_SAT));

    // Start pulsed mid-run is ignored
    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    run_check("restart_ignored", 5, 16'd19, 16'd22, 16'd43, 16'd50, 1'b0);

    // Reset during the second element's MAC
    load(8'd2, 8'd0, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    base_w = wq_addr.size();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("abort_in_mac_rd_en", 32'(rd_en_a), 32'd0);
    chk("abort_in_mac_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_en_c", 32'(wr_en_c), 32'd0);
    chk("abort_rd_en_a", 32'(rd_en_a), 32'd0);
    chk("abort_wr_addr_c", 32'(wr_addr_c), 32'd0);
    chk("abort_wr_data_c", 32'(wr_data_c), 32'd0);
    chk("abort_rd_addr_b", 32'(rd_addr_b), 32'd0);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    chk("abort_write_count", 32'(wq_addr.size() - base_w), 32'd1);
    chk("abort_still_idle", 32'(busy), 32'd0);
    // A=[[2,0],[1,3]] B=[[4,5],[6,7]] -> [[8,10],[22,26]]
    run_check("after_abort", 0, 16'd8, 16'd10, 16'd22, 16'd26, 1'b0);

    // Start held high: back-to-back runs with one IDLE cycle between
    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    base_w = wq_addr.size();
    base_d = done_cnt;
    start = 1'b1;
    step();
    wait_done("held1");
    step();
    chk("held_gap_idle", 32'(busy), 32'd0);
    step();
    chk("held_next_busy", 32'(busy), 32'd1);
    chk("held_next_read", 32'(rd_en_a), 32'd1);
    start = 1'b0;
    wait_done("held2");
    step();
    chk("held_done_count", 32'(done_cnt - base_d), 32'd2);
    chk("held_write_count", 32'(wq_addr.size() - base_w), 32'd8);
    if (wq_addr.size() - base_w == 8) begin
      chk("held_run2_data0", 32'(wq_data[base_w + 4]), 32'd19);
      chk("held_run2_data3", 32'(wq_data[base_w + 7]), 32'd50);
      chk("held_run2_addr3", 32'(wq_addr[base_w + 7]), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
